result_store: RTL and testbench

Writes the eight MAC accumulator results back to memory and is the write-side counterpart of the matrix-vector fetch path. A one-cycle `start` pulse from the MAC array snapshots all `sum` lanes. The block then issues one Avalon-MM write per lane to consecutive word addresses and pulses `done` after the final write is accepted. It sits between `mat_mult` and the on-chip memory write port.

---
 rtl/result_store.sv | 113 +++++++++++
 tb/tb_result_store.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/result_store.sv
// result_store: captures N MAC lane sums on start and writes them to
// consecutive memory words over Avalon-MM, pulsing done after the last beat.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start, sum      - capture request and the N unsigned lane sums
//   busy, done      - store in progress, one-cycle completion pulse
//   avm_*           - Avalon-MM write master (address/write/data/be/wait)
module result_store #(
  parameter int N = 8,
  parameter int SUM_W = 24,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SUM_W-1:0]      sum [0:N-1],
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FIN
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    nidx;
  logic [SUM_W-1:0] snap [0:N-1];
  logic             accept;

  function automatic logic [DATA_W-1:0] zext(
    input logic [SUM_W-1:0] v
  );
    logic [DATA_W-1:0] r;
    r = '0;
    r[SUM_W-1:0] = v;
    return r;
  endfunction

  assign accept = avm_write && !avm_waitrequest;
  assign nidx = idx + 1'b1;
  assign avm_byteenable = '1;

  // Outputs are computed one beat ahead so every
  // avm_* signal comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      avm_write <= 1'b0;
      avm_address <= BASE_ADDR;
      avm_writedata <= '0;
      for (int i = 0; i < N; i++) snap[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) snap[i] <= sum[i];
            idx <= '0;
            busy <= 1'b1;
            avm_write <= 1'b1;
            avm_address <= BASE_ADDR;
            avm_writedata <= zext(sum[0]);
            state <= WRITE;
          end
        end
        WRITE: begin
          if (accept) begin
            if (idx == LAST) begin
              avm_write <= 1'b0;
              done <= 1'b1;
              state <= FIN;
            end else begin
              idx <= nidx;
              avm_address <= avm_address + STEP;
              avm_writedata <= zext(snap[nidx]);
            end
          end
        end
        FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
          idx <= '0;
          avm_address <= BASE_ADDR;
          avm_writedata <= '0;
          state <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          avm_write <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_store.sv
// tb_result_store: directed checks of result_store (two instances,
// BASE_ADDR 0 and 0x40, sharing all inputs).
module tb_result_store;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] sum [0:7];
  logic        waitreq;

  logic        busy0, done0, wr0;
  logic [31:0] addr0, data0;
  logic [3:0]  be0;
  logic        busy1, done1, wr1;
  logic [31:0] addr1, data1;
  logic [3:0]  be1;

  int checks = 0;
  int passes = 0;
  int fails = 0;
  int cyc = 0;
  int nwr = 0;
  int ndone = 0;
  logic [31:0] expv [0:7];
  logic [31:0] mem [0:63];

  result_store #(.BASE_ADDR(32'h0)) u0 (
    .clk(clk), .rst(rst), .start(start), .sum(sum),
    .busy(busy0), .done(done0),
    .avm_address(addr0), .avm_write(wr0),
    .avm_writedata(data0), .avm_byteenable(be0),
    .avm_waitrequest(waitreq)
  );

  result_store #(.BASE_ADDR(32'h40)) u1 (
    .clk(clk), .rst(rst), .start(start), .sum(sum),
    .busy(busy1), .done(done1),
    .avm_address(addr1), .avm_write(wr1),
    .avm_writedata(data1), .avm_byteenable(be1),
    .avm_waitrequest(waitreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr0 && !waitreq) begin
      nwr = nwr + 1;
      mem[addr0[7:2]] = data0;
    end
    if (done0) ndone = ndone + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_wr0"}, 64'(wr0), 64'd0);
    chk({tag, "_busy0"}, 64'(busy0), 64'd0);
    chk({tag, "_done0"}, 64'(done0), 64'd0);
    chk({tag, "_wr1"}, 64'(wr1), 64'd0);
    chk({tag, "_busy1"}, 64'(busy1), 64'd0);
    chk({tag, "_done1"}, 64'(done1), 64'd0);
  endtask

  // Caller drives start=1 on the current cycle (cycle 0).
  // sl/sn: lane and stall length; pa/pb: extra start pulse cycles.
  task automatic run_store(input int sl_a, input int sn_a,
                           input int sl_b, input int sn_b,
                           input int pa, input int pb,
                           input bit chg, input int done_cyc);
    int w0;
    int d0;
    int ns;
    w0 = nwr;
    d0 = ndone;
    cyc = 0;
    step();
    start = (cyc == pa) || (cyc == pb);
    if (chg) for (int i = 0; i < 8; i++) sum[i] = 24'hFFFFFF;
    for (int i = 0; i < 8; i++) begin
      ns = (i == sl_a) ? sn_a : (i == sl_b) ? sn_b : 0;
      for (int s = 0; s <= ns; s++) begin
        waitreq = (s < ns);
        chk("beat_wr", 64'(wr0), 64'd1);
        chk("beat_addr0", 64'(addr0), 64'(4 * i));
        chk("beat_addr1", 64'(addr1), 64'(32'h40 + 4 * i));
        chk("beat_data0", 64'(data0), 64'(expv[i]));
        chk("beat_data1", 64'(data1), 64'(expv[i]));
        chk("beat_busy", 64'(busy0), 64'd1);
        chk("beat_done", 64'(done0), 64'd0);
        step();
        start = (cyc == pa) || (cyc == pb);
      end
    end
    waitreq = 1'b0;
    chk("fin_done", 64'(done0), 64'd1);
    chk("fin_done1", 64'(done1), 64'd1);
    chk("fin_busy", 64'(busy0), 64'd1);
    chk("fin_wr", 64'(wr0), 64'd0);
    chk("fin_cycle", 64'(cyc), 64'(done_cyc));
    step();
    start = (cyc == pa) || (cyc == pb);
    idle_chk("post");
    chk("nwrites", 64'(nwr - w0), 64'd8);
    chk("ndone", 64'(ndone - d0), 64'd1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 8; i++) begin
      sum[i] = 24'h100000 + 24'(i);
      expv[i] = 32'h00100000 + 32'(i);
    end
  endtask

  initial begin
    int w0;
    int d0;
    logic [23:0] y [0:7];
    rst = 1'b0;
    start = 1'b0;
    waitreq = 1'b0;
    for (int i = 0; i < 8; i++) sum[i] = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    #2 rst = 1'b1;
    #1;
    idle_chk("rst");
    chk("rst_addr0", 64'(addr0), 64'h0);
    chk("rst_addr1", 64'(addr1), 64'h40);
    chk("rst_data", 64'(data0), 64'h0);
    chk("rst_be", 64'(be0), 64'hF);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    idle_chk("idle");

    // basic store
    load_basic();
    start = 1'b1;
    run_store(-1, 0, -1, 0, -1, -1, 1'b0, 9);

    // backpressure: lane 2 stalled 3 cycles, lane 7 one cycle
    start = 1'b1;
    run_store(2, 3, 7, 1, -1, -1, 1'b0, 13);

    // snapshot isolation, then an all-ones store
    start = 1'b1;
    run_store(-1, 0, -1, 0, -1, -1, 1'b1, 9);
    for (int i = 0; i < 8; i++) expv[i] = 32'h00FFFFFF;
    start = 1'b1;
    run_store(-1, 0, -1, 0, -1, -1, 1'b0, 9);

    // start while busy (cycle 4 and FIN), then a start on cycle 10
    load_basic();
    start = 1'b1;
    run_store(-1, 0, -1, 0, 4, 9, 1'b0, 9);
    for (int i = 0; i < 8; i++) begin
      sum[i] = 24'h000A00 + 24'(i);
      expv[i] = 32'h00000A00 + 32'(i);
    end
    start = 1'b1;
    run_store(-1, 0, -1, 0, -1, -1, 1'b0, 9);

    // reset mid-store after lane 3 accepted
    load_basic();
    w0 = nwr;
    d0 = ndone;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_addr", 64'(addr0), 64'd16);
    chk("pre_rst_wr", 64'(wr0), 64'd1);
    #3 rst = 1'b1;
    #1;
    idle_chk("async_rst");
    chk("async_rst_addr1", 64'(addr1), 64'h40);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    idle_chk("after_rst");
    chk("rst_nwrites", 64'(nwr - w0), 64'd4);
    chk("rst_ndone", 64'(ndone - d0), 64'd0);
    start = 1'b1;
    run_store(-1, 0, -1, 0, -1, -1, 1'b0, 9);

    // matrix-vector product: A[r][c] = 8r+c+1, x[c] = c+3
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int r = 0; r < 8; r++) begin
      y[r] = '0;
      for (int c = 0; c < 8; c++)
        y[r] = y[r] + 24'((8 * r + c + 1) * (c + 3));
      sum[r] = y[r];
      expv[r] = 32'(y[r]);
    end
    start = 1'b1;
    run_store(-1, 0, -1, 0, -1, -1, 1'b0, 9);
    for (int r = 0; r < 8; r++)
      chk("mem_image", 64'(mem[r]), 64'(y[r]));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
